// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the register-access SPI master.
// Holds the FSM state encoding, command-byte layout and frame length.
package spi_reg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int FRAME_BITS = 16;

endpackage

// File: rtl/spi_reg_tick.sv
// Half-period divider: pulses tick on the last clk of each SPI phase.
// Ports: clk, rst (async high), clr (hold at zero), tick (phase end).
module spi_reg_tick
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_reg_master.sv
// Register SPI master: 16-bit {cmd, data} frames, mode 0, MSB first.
// Ports: clk, rst, start/rw/addr/wdata in, busy/done/rdata out,
// spi_cs/spi_clk/spi_mosi out, spi_miso in.
// Macro SPI_REG_MASTER_READ_EN enables the read path; without it
// every frame is a write and rdata is tied to zero.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        rdata,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  state_t      state, state_n;
  logic [15:0] sh, sh_n;
  logic [4:0]  bitcnt, bit_n;
  logic        sclk_n, cs_n, busy_n, done_n;
  logic        load, sample, tick, rw_eff;
  logic [7:0]  cmd;

`ifdef SPI_REG_MASTER_READ_EN
  assign rw_eff = rw;
`else
  logic unused_in;
  assign rw_eff    = 1'b1;
  assign unused_in = ^{rw, spi_miso};
`endif

  spi_reg_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );

  always_comb begin
    cmd             = '0;
    cmd[ADDR_W-1:0] = addr;
    cmd[CMD_RW_BIT] = rw_eff;
  end

  assign spi_mosi = sh[15];

  always_comb begin
    state_n = state;
    sh_n    = sh;
    bit_n   = bitcnt;
    sclk_n  = spi_clk;
    cs_n    = spi_cs;
    busy_n  = busy;
    done_n  = 1'b0;
    load    = 1'b0;
    sample  = 1'b0;
    unique case (state)
      IDLE: load = start;
      SETUP: begin
        if (tick) begin
          state_n = SHIFT;
          sclk_n  = 1'b1;
          bit_n   = '0;
          sample  = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (spi_clk) begin
            sclk_n = 1'b0;
            sh_n   = {sh[14:0], 1'b0};
          end else if (bitcnt == LAST_BIT) begin
            state_n = HOLD;
          end else begin
            bit_n  = bitcnt + 5'd1;
            sclk_n = 1'b1;
            sample = 1'b1;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_n = GAP;
          cs_n    = 1'b1;
        end
      end
      GAP: begin
        if (tick) begin
          done_n = 1'b1;
          // A start waiting at the end of GAP chains the next
          // frame, so deselect lasts exactly one GAP.
          if (start) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = SETUP;
      sh_n    = {cmd, rw_eff ? wdata : 8'h00};
      bit_n   = '0;
      sclk_n  = 1'b0;
      cs_n    = 1'b0;
      busy_n  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      bitcnt  <= '0;
      spi_clk <= 1'b0;
      spi_cs  <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      bitcnt  <= bit_n;
      spi_clk <= sclk_n;
      spi_cs  <= cs_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

`ifdef SPI_REG_MASTER_READ_EN
  logic       rw_q;
  logic [7:0] rx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rw_q  <= 1'b0;
      rx    <= '0;
      rdata <= '0;
    end else begin
      if (load) rw_q <= rw;
      if (sample) rx <= {rx[6:0], spi_miso};
      if (done_n && !rw_q) rdata <= rx;
    end
  end
`else
  assign rdata = 8'h00;
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with a register-file slave model.
// Covers write/read frames, ignored start, abort by reset, chaining.
module tb_spi_reg_master;

`ifdef SPI_REG_MASTER_READ_EN
  localparam bit RD = 1'b1;
`else
  localparam bit RD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       busy, done;
  logic [7:0] rdata;
  logic       spi_cs, spi_clk, spi_mosi;
  logic       spi_miso = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          rises = 0;
  int          done_cnt = 0;
  logic [15:0] mframe = '0;
  logic [7:0]  rd = '0;

  always #5 clk = ~clk;

  spi_reg_master #(
    .CLK_DIV(4),
    .ADDR_W (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rw      (rw),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .spi_cs  (spi_cs),
    .spi_clk (spi_clk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  function automatic logic [7:0] slave_reg(input logic [4:0] a);
    return (a == 5'd23) ? 8'hE5 : ({3'b000, a} ^ 8'h5A);
  endfunction

  // Slave: capture MOSI on rising SCLK, present reply bit for next edge.
  always @(posedge spi_clk) begin
    rises = rises + 1;
    mframe = {mframe[14:0], spi_mosi};
    if (rises == 8) rd = slave_reg(mframe[4:0]);
    if (rises >= 8 && rises < 16) spi_miso = rd[3'(15 - rises)];
    else spi_miso = 1'b0;
  end

  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic r, input logic [4:0] a,
                        input logic [7:0] d);
    @(negedge clk);
    rw = r;
    addr = a;
    wdata = d;
    start = 1'b1;
    rises = 0;
    spi_miso = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic xfer(input string tag, input logic r,
                      input logic [4:0] a, input logic [7:0] d,
                      input logic [15:0] exp_frame,
                      input logic [7:0] exp_rdata);
    int lat;
    launch(r, a, d);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_early"}, {31'd0, busy}, 32'd1);
    chk({tag, "_cs_early"}, {31'd0, spi_cs}, 32'd0);
    wait_done(lat);
    lat++;
    chk({tag, "_latency"}, lat, 141);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_frame"}, {16'd0, mframe}, {16'd0, exp_frame});
    chk({tag, "_rises"}, rises, 16);
    chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, exp_rdata});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (rises < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("rises_reach", rises, n);
  endtask

  initial begin
    int d0, hi, t, lat;
    repeat (2) @(negedge clk);
    chk("rst_cs", {31'd0, spi_cs}, 32'd1);
    chk("rst_sclk", {31'd0, spi_clk}, 32'd0);
    chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer("wr_a5", 1'b1, 5'd16, 8'hA5, 16'h90A5, 8'h00);
    xfer("rd_23", 1'b0, 5'd23, 8'h3C,
         RD ? 16'h1700 : 16'h973C, RD ? 8'hE5 : 8'h00);

    // start during bit 3 must be ignored
    d0 = done_cnt;
    launch(1'b1, 5'd2, 8'h5A);
    @(negedge clk);
    start = 1'b0;
    wait_rises(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (160) @(negedge clk);
    chk("ign_done_cnt", done_cnt, d0 + 1);
    chk("ign_rises", rises, 16);
    chk("ign_frame", {16'd0, mframe}, 32'h825A);
    chk("ign_busy", {31'd0, busy}, 32'd0);
    chk("ign_rdata", {24'd0, rdata}, RD ? 32'hE5 : 32'h00);

    // asynchronous abort during bit 5
    d0 = done_cnt;
    launch(1'b1, 5'd9, 8'hFF);
    @(negedge clk);
    start = 1'b0;
    wait_rises(6);
    chk("abort_sclk_pre", {31'd0, spi_clk}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_cs", {31'd0, spi_cs}, 32'd1);
    chk("abort_sclk", {31'd0, spi_clk}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    xfer("post_abort", 1'b1, 5'd5, 8'h3C, 16'h853C, 8'h00);

    // start held across done chains a second frame
    d0 = done_cnt;
    launch(1'b1, 5'd1, 8'h11);
    hi = 0;
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
      if (t > 1 && spi_cs === 1'b1) hi++;
    end
    start = 1'b0;
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    chk("b2b_gap_cycles", hi, 4);
    @(negedge clk);
    wait_done(lat);
    repeat (10) @(negedge clk);
    chk("b2b_done_cnt", done_cnt, d0 + 2);
    chk("b2b_rises", rises, 32);
    chk("b2b_frame", {16'd0, mframe}, 32'h8111);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    xfer("rd_3", 1'b0, 5'd3, 8'h00,
         RD ? 16'h0300 : 16'h8300, RD ? 8'h59 : 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
